// File: rtl/ttt_pkg.sv
// Shared constants for the tic-tac-toe candidate scanner: board geometry,
// the eight win-line cell masks and the scan FSM state encoding.
package ttt_pkg;

  localparam int CELLS   = 9;
  localparam int N_CAND  = 9;
  localparam int SEL_W   = 4;
  localparam int N_LINES = 8;
  localparam int LINE_W  = 3;

  // Rows, then columns, then diagonals 0-4-8 and 2-4-6.
  localparam logic [CELLS-1:0] WIN_MASK [0:N_LINES-1] = '{
    9'h007, 9'h038, 9'h1C0,
    9'h049, 9'h092, 9'h124,
    9'h111, 9'h054
  };

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    REPORT = 2'd2
  } state_t;

endpackage

// File: rtl/win_line_detect.sv
// Combinational win-line test on one 9-bit occupancy word; reports the
// lowest-numbered completed line when several are complete.
module win_line_detect
  import ttt_pkg::*;
(
  input  logic [CELLS-1:0]  i_word,
  output logic              o_hit,
  output logic [LINE_W-1:0] o_line
);

  always_comb begin
    o_hit  = 1'b0;
    o_line = '0;
    // Walk from the highest line down so the lowest hit ends up winning.
    for (int l = N_LINES - 1; l >= 0; l--) begin
      if ((i_word & WIN_MASK[l]) == WIN_MASK[l]) begin
        o_hit  = 1'b1;
        o_line = LINE_W'(l);
      end
    end
  end

endmodule

// File: rtl/win_scan_ctrl.sv
// Walks the 9:1 candidate-board mux one select per cycle and reports the
// first legal candidate that completes a win line.
//
//   state  | meaning
//   IDLE   | sel_o parked at 0, waiting for start_i
//   SCAN   | evaluating candidate sel_o against the win lines
//   REPORT | done_o pulse, results valid
module win_scan_ctrl
  import ttt_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [N_CAND-1:0] valid_mask_i,
  input  logic [CELLS-1:0]  mux_data_i,
  output logic [SEL_W-1:0]  sel_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              found_o,
  output logic [SEL_W-1:0]  win_idx_o,
  output logic [LINE_W-1:0] win_line_o
);

  state_t              r_state, w_state_nxt;
  logic [SEL_W-1:0]    r_sel, w_sel_nxt;
  logic [N_CAND-1:0]   r_mask, w_mask_nxt;
  logic                r_found, w_found_nxt;
  logic [SEL_W-1:0]    r_idx, w_idx_nxt;
  logic [LINE_W-1:0]   r_line, w_line_nxt;
  logic                w_hit;
  logic [LINE_W-1:0]   w_hit_line;

  win_line_detect u_detect (
    .i_word (mux_data_i),
    .o_hit  (w_hit),
    .o_line (w_hit_line)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_mask_nxt  = r_mask;
    w_found_nxt = r_found;
    w_idx_nxt   = r_idx;
    w_line_nxt  = r_line;
    case (r_state)
      IDLE: begin
        w_sel_nxt = '0;
        if (start_i) begin
          w_mask_nxt  = valid_mask_i;
          w_found_nxt = 1'b0;
          w_idx_nxt   = '0;
          w_line_nxt  = '0;
          w_state_nxt = SCAN;
        end
      end
      SCAN: begin
        // Illegal candidates still burn their cycle so latency tracks index.
        if (r_mask[r_sel] && w_hit) begin
          w_found_nxt = 1'b1;
          w_idx_nxt   = r_sel;
          w_line_nxt  = w_hit_line;
          w_state_nxt = REPORT;
        end else if (r_sel == SEL_W'(N_CAND - 1)) begin
          w_state_nxt = REPORT;
        end else begin
          w_sel_nxt = r_sel + 1'b1;
        end
      end
      REPORT: begin
        w_sel_nxt   = '0;
        w_state_nxt = IDLE;
      end
      default: begin
        w_sel_nxt   = '0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sel   <= '0;
      r_mask  <= '0;
      r_found <= 1'b0;
      r_idx   <= '0;
      r_line  <= '0;
    end else begin
      r_sel   <= w_sel_nxt;
      r_mask  <= w_mask_nxt;
      r_found <= w_found_nxt;
      r_idx   <= w_idx_nxt;
      r_line  <= w_line_nxt;
    end
  end

  assign sel_o      = r_sel;
  assign busy_o     = (r_state != IDLE);
  assign done_o     = (r_state == REPORT);
  assign found_o    = r_found;
  assign win_idx_o  = r_idx;
  assign win_line_o = r_line;

endmodule

// File: tb/tb_win_scan_ctrl.sv
// Self-checking bench for win_scan_ctrl: directed scenarios plus randomized
// scans compared against a cell-level reference model of the win rules.
module tb_win_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_i;
  logic [8:0] valid_mask_i;
  logic [8:0] mux_data_i;
  logic [3:0] sel_o;
  logic       busy_o;
  logic       done_o;
  logic       found_o;
  logic [3:0] win_idx_o;
  logic [2:0] win_line_o;

  logic [8:0] cand [0:8];
  int n_checks = 0;
  int n_fail   = 0;

  // Each win line as its three cell indices.
  int lc [0:7][0:2] = '{'{0,1,2}, '{3,4,5}, '{6,7,8},
                        '{0,3,6}, '{1,4,7}, '{2,5,8},
                        '{0,4,8}, '{2,4,6}};

  win_scan_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .valid_mask_i (valid_mask_i),
    .mux_data_i   (mux_data_i),
    .sel_o        (sel_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .found_o      (found_o),
    .win_idx_o    (win_idx_o),
    .win_line_o   (win_line_o)
  );

  always #5 clk = ~clk;

  always_comb mux_data_i = (sel_o < 4'd9) ? cand[sel_o] : 9'h000;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic [8:0] m, output bit f, output int idx, output int ln);
    f = 0; idx = 0; ln = 0;
    for (int k = 0; k < 9; k++) begin
      if (!f && m[k]) begin
        for (int l = 0; l < 8; l++) begin
          if (!f && cand[k][lc[l][0]] && cand[k][lc[l][1]] && cand[k][lc[l][2]]) begin
            f = 1; idx = k; ln = l;
          end
        end
      end
    end
  endfunction

  task automatic set_all(input logic [8:0] v);
    for (int k = 0; k < 9; k++) cand[k] = v;
  endtask

  // Called at a negedge with the DUT idle; that cycle is cycle 0.
  task automatic run_scan(input logic [8:0] m, input int pulse_at);
    bit f; int ei, el, done_cyc; bit seen;
    model(m, f, ei, el);
    done_cyc = f ? ei + 2 : 10;
    valid_mask_i = m;
    start_i = 1'b1;
    @(negedge clk);
    valid_mask_i = 9'($urandom);
    seen = 0;
    for (int c = 1; c <= 12 && !seen; c++) begin
      start_i = (c == pulse_at);
      if (done_o) begin
        seen = 1;
        chk("done_cycle", c, done_cyc);
        chk("busy_report", 32'(busy_o), 1);
        chk("found", 32'(found_o), 32'(f));
        chk("win_idx", 32'(win_idx_o), ei);
        chk("win_line", 32'(win_line_o), el);
      end else begin
        chk("busy_scan", 32'(busy_o), 1);
        chk("sel_scan", 32'(sel_o), c - 1);
        @(negedge clk);
      end
    end
    if (!seen) chk("done_timeout", 0, 1);
    start_i = 1'b0;
    @(negedge clk);
    chk("idle_busy", 32'(busy_o), 0);
    chk("idle_done", 32'(done_o), 0);
    chk("idle_sel", 32'(sel_o), 0);
    chk("hold_found", 32'(found_o), 32'(f));
  endtask

  initial begin
    int dones;
    logic [8:0] m;
    rst = 1'b1; start_i = 1'b0; valid_mask_i = 9'h000;
    set_all(9'h000);

    // Reset
    @(negedge clk);
    @(negedge clk);
    chk("rst_sel", 32'(sel_o), 0);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_done", 32'(done_o), 0);
    chk("rst_found", 32'(found_o), 0);
    chk("rst_idx", 32'(win_idx_o), 0);
    chk("rst_line", 32'(win_line_o), 0);
    rst = 1'b0;
    @(negedge clk);

    // Diagonal 2-4-6 on candidate 4
    set_all(9'h000); cand[4] = 9'h054;
    run_scan(9'h1FF, 0);

    // No line anywhere
    set_all(9'h0AA);
    run_scan(9'h1FF, 0);

    // Illegal candidate 2 skipped
    set_all(9'h000); cand[2] = 9'h007; cand[6] = 9'h049;
    run_scan(9'h1FB, 0);

    // Empty mask: full scan, nothing found
    set_all(9'h1FF);
    run_scan(9'h000, 0);

    // Full board at candidate 0: lowest line wins
    set_all(9'h000); cand[0] = 9'h1FF;
    run_scan(9'h1FF, 0);

    // Start pulsed mid-scan is ignored
    set_all(9'h0AA);
    run_scan(9'h1FF, 3);

    // Reset while sel_o=3 aborts without done_o
    set_all(9'h0AA);
    valid_mask_i = 9'h1FF; start_i = 1'b1;
    @(negedge clk); start_i = 1'b0;
    @(negedge clk); @(negedge clk); @(negedge clk);
    chk("pre_rst_sel", 32'(sel_o), 3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 32'(busy_o), 0);
    chk("abort_sel", 32'(sel_o), 0);
    chk("abort_found", 32'(found_o), 0);
    dones = 0;
    for (int c = 0; c < 12; c++) begin
      if (done_o) dones++;
      @(negedge clk);
    end
    chk("abort_no_done", dones, 0);

    // Start held high: back-to-back scans
    set_all(9'h000); cand[1] = 9'h038;
    valid_mask_i = 9'h1FF; start_i = 1'b1;
    @(negedge clk);
    chk("b2b_c1_sel", 32'(sel_o), 0);
    @(negedge clk);
    chk("b2b_c2_sel", 32'(sel_o), 1);
    @(negedge clk);
    chk("b2b_c3_done", 32'(done_o), 1);
    chk("b2b_c3_idx", 32'(win_idx_o), 1);
    chk("b2b_c3_line", 32'(win_line_o), 1);
    @(negedge clk);
    chk("b2b_c4_busy", 32'(busy_o), 0);
    chk("b2b_c4_found", 32'(found_o), 1);
    @(negedge clk);
    chk("b2b_c5_busy", 32'(busy_o), 1);
    chk("b2b_c5_sel", 32'(sel_o), 0);
    chk("b2b_c5_found", 32'(found_o), 0);
    chk("b2b_c5_idx", 32'(win_idx_o), 0);
    chk("b2b_c5_line", 32'(win_line_o), 0);
    @(negedge clk);
    start_i = 1'b0;
    @(negedge clk);
    chk("b2b_c7_done", 32'(done_o), 1);
    chk("b2b_c7_found", 32'(found_o), 1);
    @(negedge clk);
    chk("b2b_c8_busy", 32'(busy_o), 0);

    // Randomized scans
    for (int it = 0; it < 40; it++) begin
      for (int k = 0; k < 9; k++) cand[k] = 9'($urandom & $urandom);
      m = (it % 8 == 7) ? 9'h000 : 9'($urandom);
      run_scan(m, int'($urandom_range(0, 5)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
